// File: rtl/detect_pkg.sv
// Shared constants and types for the raw-line FIFO arbiter.
//   DATA_W     : FIFO word width (one period = 16 pixels x 8 bit)
//   PERIOD_NUM : periods per sensor line
//   CNT_W      : width of the per-requester line counters
//   state_e    : arbiter FSM encoding
//   REQ_DET / REQ_CAP : requester indices (droplet detector / raw capture)
package detect_pkg;

  localparam int unsigned DATA_W     = 128;
  localparam int unsigned PERIOD_NUM = 21;
  localparam int unsigned CNT_W      = 16;

  localparam int unsigned REQ_DET = 0;
  localparam int unsigned REQ_CAP = 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StServe   = 2'd1,
    StHandoff = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way requester picker with round-robin or fixed-priority tie-break.
//   clk, reset : clock, asynchronous active-low reset
//   req        : requester request levels
//   prio_mode  : 0 = round-robin, 1 = requester REQ_DET always wins a tie
//   advance    : a grant is being issued this cycle; record who got it
//   pick       : one-hot winner (0 when req == 0)
module rr_pick2
  import detect_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       prio_mode,
  input  logic       advance,
  output logic [1:0] pick
);

  // Index of the requester served last; reset to REQ_CAP so REQ_DET wins the first tie.
  logic last_q;

  always_comb begin
    pick = 2'b00;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (prio_mode || last_q) ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (advance && (|pick)) begin
      last_q <= pick[REQ_CAP];
    end
  end

endmodule

// File: rtl/detect_line_arbiter.sv
// Line-atomic arbiter sharing one raw-line input FIFO between two readers.
// An owner keeps the FIFO for exactly PERIOD_NUM forwarded reads.
//   clk, reset      : clock, asynchronous active-low reset
//   fifo_rdempty    : input FIFO empty
//   fifo_rdreq      : input FIFO read strobe (combinational from owner's rd)
//   fifo_rddata     : FIFO data, valid the cycle after fifo_rdreq
//   prio_mode       : 0 = round-robin, 1 = fixed priority (requester 0 wins)
//   req             : per-requester request for the next whole line
//   rd              : per-requester read strobes
//   empty           : per-requester empty view (empty unless owner and FIFO has data)
//   rddata          : broadcast FIFO data
//   grant           : one-hot current owner
//   line_done       : one-cycle pulse after the owner's last period is read
//   lines_served0/1 : completed lines per requester (wrapping)
//   err_sticky      : [0] read by non-owner, [1] owner read while empty
module detect_line_arbiter
#(
  parameter int unsigned DATA_W     = detect_pkg::DATA_W,
  parameter int unsigned PERIOD_NUM = detect_pkg::PERIOD_NUM,
  parameter int unsigned CNT_W      = detect_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_rdempty,
  output logic              fifo_rdreq,
  input  logic [DATA_W-1:0] fifo_rddata,
  input  logic              prio_mode,
  input  logic [1:0]        req,
  input  logic [1:0]        rd,
  output logic [1:0]        empty,
  output logic [DATA_W-1:0] rddata,
  output logic [1:0]        grant,
  output logic [1:0]        line_done,
  output logic [CNT_W-1:0]  lines_served0,
  output logic [CNT_W-1:0]  lines_served1,
  output logic [1:0]        err_sticky
);

  import detect_pkg::*;

  localparam logic [7:0] LastPeriod = 8'(PERIOD_NUM - 1);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       done_q, done_d;
  logic [CNT_W-1:0] served0_q, served0_d;
  logic [CNT_W-1:0] served1_q, served1_d;
  logic [1:0]       err_q, err_d;

  logic       owner_rd;
  logic       fwd;
  logic       advance;
  logic [1:0] pick;

  assign owner_rd   = |(rd & grant_q);
  assign fwd        = owner_rd & ~fifo_rdempty;
  assign fifo_rdreq = fwd;
  assign empty      = {2{fifo_rdempty}} | ~grant_q;
  assign rddata     = fifo_rddata;

  assign grant         = grant_q;
  assign line_done     = done_q;
  assign lines_served0 = served0_q;
  assign lines_served1 = served1_q;
  assign err_sticky    = err_q;

  rr_pick2 u_pick (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .prio_mode (prio_mode),
    .advance   (advance),
    .pick      (pick)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    done_d    = 2'b00;
    served0_d = served0_q;
    served1_d = served1_q;
    err_d     = err_q;
    advance   = 1'b0;

    // Outside SERVE grant_q is zero, so every read there counts as a non-owner read.
    if (|(rd & ~grant_q)) err_d[0] = 1'b1;
    if (owner_rd && fifo_rdempty) err_d[1] = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = pick;
          advance = 1'b1;
          state_d = StServe;
        end
      end
      StServe: begin
        // req is deliberately ignored here: the grant is held to the line end.
        if (fwd) begin
          if (cnt_q == LastPeriod) begin
            cnt_d   = 8'd0;
            grant_d = 2'b00;
            done_d  = grant_q;
            if (grant_q[REQ_DET]) served0_d = served0_q + CNT_W'(1);
            if (grant_q[REQ_CAP]) served1_d = served1_q + CNT_W'(1);
            state_d = StHandoff;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StHandoff: begin
        // Lets the owner consume the last data word before ownership can change.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      cnt_q     <= 8'd0;
      done_q    <= 2'b00;
      served0_q <= '0;
      served1_q <= '0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      served0_q <= served0_d;
      served1_q <= served1_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_detect_line_arbiter.sv
// Randomised bench for detect_line_arbiter with a line-level reference model and
// a scoreboard for line completions and forwarded data.
module tb_detect_line_arbiter;

  localparam int P  = 21;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_rdempty = 1'b0;
  logic          fifo_rdreq;
  logic [127:0]  fifo_rddata = '0;
  logic          prio_mode = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    rd = 2'b00;
  logic [1:0]    empty;
  logic [127:0]  rddata;
  logic [1:0]    grant;
  logic [1:0]    line_done;
  logic [CW-1:0] lines_served0;
  logic [CW-1:0] lines_served1;
  logic [1:0]    err_sticky;

  always #5 clk = ~clk;

  detect_line_arbiter #(
    .DATA_W     (128),
    .PERIOD_NUM (P),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_rdempty  (fifo_rdempty),
    .fifo_rdreq    (fifo_rdreq),
    .fifo_rddata   (fifo_rddata),
    .prio_mode     (prio_mode),
    .req           (req),
    .rd            (rd),
    .empty         (empty),
    .rddata        (rddata),
    .grant         (grant),
    .line_done     (line_done),
    .lines_served0 (lines_served0),
    .lines_served1 (lines_served1),
    .err_sticky    (err_sticky)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected expected=none", nm);
  endtask

  function automatic logic [127:0] mk_word(input int i);
    logic [31:0] v;
    v = i;
    return {v ^ 32'h5a5a_0000, ~v, v * 32'd3, 32'hc0de_0000 | {16'h0, v[15:0]}};
  endfunction

  // Bench-side FIFO: each forwarded read delivers the next word one cycle later.
  int fifo_pop = 0;
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      fifo_rddata <= mk_word(fifo_pop);
      fifo_pop    <= fifo_pop + 1;
    end
  end

  // Reference model state (line-level view of ownership).
  typedef struct {
    logic [1:0]    mask;
    logic [CW-1:0] cnt;
  } done_t;

  int           m_owner = -1;
  int           m_count = 0;
  int           m_last = 1;
  int           m_gap = 0;
  int           m_served[2] = '{0, 0};
  logic [1:0]   m_err = 2'b00;
  int           m_pop = 0;
  done_t        done_q[$];
  logic [127:0] data_q[$];

  function automatic logic [1:0] exp_grant();
    if (m_owner < 0) return 2'b00;
    return (m_owner == 0) ? 2'b01 : 2'b10;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents data or a line completion.
  logic  fwd_prev = 1'b0;
  done_t mon_e;
  always @(posedge clk) fwd_prev <= fifo_rdreq;

  always @(negedge clk) begin
    if (fwd_prev) begin
      if (data_q.size() == 0) fail_now("rddata_unexpected");
      else chk("rddata", rddata, data_q.pop_front());
    end
    if (line_done !== 2'b00) begin
      if (done_q.size() == 0) begin
        fail_now("line_done_unexpected");
      end else begin
        mon_e = done_q.pop_front();
        chk("line_done", {126'b0, line_done}, {126'b0, mon_e.mask});
        chk("lines_served_at_done", mon_e.mask[0] ? lines_served0 : lines_served1, mon_e.cnt);
      end
    end
  end

  task automatic check_regs();
    chk("grant", grant, exp_grant());
    chk("lines_served0", lines_served0, CW'(m_served[0]));
    chk("lines_served1", lines_served1, CW'(m_served[1]));
    chk("err_sticky", err_sticky, m_err);
  endtask

  task automatic step(input logic [1:0] r, input logic pm, input logic [1:0] rdv,
                      input logic emp);
    logic [1:0] g;
    logic       f;
    int         w;
    done_t      e;
    @(posedge clk);
    #1;
    check_regs();
    req = r;
    prio_mode = pm;
    rd = rdv;
    fifo_rdempty = emp;
    #1;
    g = exp_grant();
    f = (m_owner >= 0) && rdv[m_owner[0]] && !emp;
    chk("fifo_rdreq", {127'b0, fifo_rdreq}, {127'b0, f});
    chk("empty", {126'b0, empty}, {126'b0, ({emp, emp} | ~g)});

    if ((rdv & ~g) != 2'b00) m_err[0] = 1'b1;
    if (m_owner >= 0 && rdv[m_owner[0]] && emp) m_err[1] = 1'b1;

    if (m_owner >= 0) begin
      if (f) begin
        data_q.push_back(mk_word(m_pop));
        m_pop++;
        m_count++;
        if (m_count == P) begin
          m_served[m_owner] = (m_served[m_owner] + 1) % (1 << CW);
          e.mask = g;
          e.cnt  = CW'(m_served[m_owner]);
          done_q.push_back(e);
          m_owner = -1;
          m_count = 0;
          m_gap = 1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != 2'b00) begin
      if (r == 2'b01) w = 0;
      else if (r == 2'b10) w = 1;
      else if (pm) w = 0;
      else w = 1 - m_last;
      m_owner = w;
      m_last = w;
      m_count = 0;
    end
  endtask

  task automatic rand_step(input logic pm, input int both_pct, input int empty_pct);
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] rdv;
    g = exp_grant();
    r = ($urandom_range(0, 99) < both_pct) ? 2'b11 : 2'($urandom_range(0, 3));
    for (int j = 0; j < 2; j++) begin
      rdv[j] = g[j] ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 4);
    end
    step(r, pm, rdv, $urandom_range(0, 99) < empty_pct);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_count = 0;
    m_last = 1;
    m_gap = 0;
    m_served[0] = 0;
    m_served[1] = 0;
    m_err = 2'b00;
  endtask

  task automatic check_reset_state();
    chk("rst_grant", {126'b0, grant}, 128'd0);
    chk("rst_line_done", {126'b0, line_done}, 128'd0);
    chk("rst_served0", {112'b0, lines_served0}, 128'd0);
    chk("rst_served1", {112'b0, lines_served1}, 128'd0);
    chk("rst_err", {126'b0, err_sticky}, 128'd0);
    chk("rst_fifo_rdreq", {127'b0, fifo_rdreq}, 128'd0);
  endtask

  initial begin
    bit hit;
    #3;
    check_reset_state();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Round-robin contention, heavy ties.
    for (int i = 0; i < 700; i++) rand_step(1'b0, 70, 15);
    // Fixed priority.
    for (int i = 0; i < 500; i++) rand_step(1'b1, 70, 15);
    // Mixed mode.
    for (int i = 0; i < 300; i++) rand_step(1'($urandom_range(0, 1)), 40, 10);

    // Mid-line reset once an owner is at least 7 periods in.
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      step(2'b01, 1'b0, exp_grant(), 1'b0);
      if (m_owner >= 0 && m_count >= 7) hit = 1'b1;
    end
    if (!hit) fail_now("midline_reset_not_reached");
    @(posedge clk);
    #1;
    req = 2'b00;
    rd = 2'b00;
    reset = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // After release: full lines again, both modes.
    for (int i = 0; i < 400; i++) rand_step(1'($urandom_range(0, 1)), 50, 10);

    // Drain: owner reads to line end, no new requests.
    for (int i = 0; i < 60; i++) step(2'b00, 1'b0, exp_grant(), 1'b0);
    @(negedge clk);
    #1;
    chk("done_queue_drained", 128'(done_q.size()), 128'd0);
    chk("data_queue_drained", 128'(data_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/detect_line_arbiter.md
Name: detect_line_arbiter

Overview:
- Shares the single raw-line input FIFO (128-bit periods, 21 periods per sensor line) between two readers.
  - Requester 0 is the droplet detector.
  - Requester 1 is the raw-capture/debug path.
- Grants are line-atomic: once a requester owns the FIFO, it keeps it for exactly PERIOD_NUM reads, so no reader ever sees a split line.
- Sits between the input FIFO and both readers. Readers keep their existing rdfifo/rddata/rdempty handshake unchanged.

Parameters:
- DATA_W, 128, FIFO word width (one period = 16 pixels x 8 bit).
- PERIOD_NUM, 21, periods per line; range 1..255.
- CNT_W, 16, width of the per-requester line counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- fifo_rdempty  in  1  input FIFO empty.
- fifo_rdreq  out  1  input FIFO read strobe.
- fifo_rddata  in  DATA_W  FIFO read data; valid the cycle after fifo_rdreq.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (requester 0 wins).
- req  in  2  requester wants the next whole line (level).
- rd  in  2  per-requester read strobe (rdfifo-style, 1-cycle pulse).
- empty  out  2  per-requester empty view.
- rddata  out  DATA_W  broadcast FIFO data.
- grant  out  2  one-hot current owner; 0 when idle.
- line_done  out  2  1-cycle pulse after the owner's last period is read.
- lines_served0, lines_served1  out  CNT_W  completed lines per requester.
- err_sticky  out  2  [0] = read by non-owner, [1] = read while empty; cleared only by reset.

Behaviour:
- Reset values: grant=0, fifo_rdreq path idle, line_done=0, both counters=0, err_sticky=0, period count=0, RR pointer=requester 1 (so requester 0 wins the first tie). FSM goes to IDLE.
- Combinational paths:
  - fifo_rdreq = |(rd & grant) & ~fifo_rdempty.
  - empty[j] = fifo_rdempty | ~grant[j].
  - rddata = fifo_rddata, zero added latency. A reader's read-to-data timing is identical to a direct FIFO connection.
- FSM states: IDLE, SERVE, HANDOFF.
- IDLE:
  - req==0: stay in IDLE.
  - Exactly one req bit set: grant that requester next cycle, go to SERVE.
  - Both req bits set with prio_mode=1: grant requester 0.
  - Both req bits set with prio_mode=0: grant the requester not served last, then update the RR pointer.
- SERVE:
  - Each forwarded read increments the period count (8 bit).
  - On the read that brings the count to PERIOD_NUM: next cycle, pulse line_done[owner], increment lines_served[owner], clear the count, drop grant to 0, go to HANDOFF.
  - The owner's req may deassert mid-line; it is ignored and the grant is held to the line end.
- HANDOFF: one idle cycle so the last data word is consumed before ownership changes. Then go to IDLE, which arbitrates the same cycle it is entered.
  - Worst-case gap between lines: 2 cycles.
- Reads by the non-owner: not forwarded, do not count, set err_sticky[0].
- Owner reads while fifo_rdempty=1: not forwarded, do not count, set err_sticky[1].
- rd asserted on both bits in the same cycle: only the owner's read is honoured; err_sticky[0] is set for the other.
- Counters: lines_served wraps modulo 2^CNT_W without saturation.
- PERIOD_NUM=1: every single read completes a line (SERVE lasts one read).
- Reset mid-line: grant clears immediately (asynchronous). The partial line is abandoned, and the owner must resynchronise on its next grant. The arbiter does not drain the FIFO.

Decomposition:
- Shared package detect_pkg holds: PERIOD_NUM, DATA_W, the FSM state encoding, and the requester index constants REQ_DET=0 and REQ_CAP=1.
- One sub-module, rr_pick2: 2-way round-robin/fixed-priority picker plus the pointer register.
- Counters and FSM stay in the top level.

Test Plan:
- Single requester line: req=01, 21 rd pulses with the FIFO non-empty -> 21 fifo_rdreq; line_done[0] pulses 1 cycle after the 21st read; lines_served0=1; grant=00 in HANDOFF.
- Round-robin contention: req=11 held, prio_mode=0 -> grants alternate 01, 10, 01 per line; lines_served0=2 and lines_served1=1 after 3 lines.
- Fixed priority: req=11, prio_mode=1 over 3 lines -> grant 01 for all 3; requester 1 sees empty[1]=1 throughout.
- Non-owner read: requester 1 pulses rd during requester 0's line -> no fifo_rdreq; err_sticky=01; period count unchanged.
- Empty stall: FIFO goes empty after period 10 -> empty[owner]=1; the owner's reads are ignored with err_sticky[1] set; after refill, the line completes at exactly 21 forwarded reads.
- Reset mid-line: assert reset after period 7 -> grant=00 within the same cycle; counts and flags are 0; after release, the first line served is a full 21 periods.
